audio_clip_player: RTL and testbench
====================================

// Module: audio_clip_player
// PURPOSE
//  Multi-clip flash audio playback engine. Holds a runtime-programmable table of
//  NUM_CLIPS (start address, length) entries and streams a selected clip from
//  flash_manager (read mode) to the AC97 output at the ready-strobe rate / DECIM.
//  Supports one-shot or loop mode, retrigger, and underrun detection.
//  Sits between audio control logic, flash_manager (raddr/doread/frdata/busy)
//  and the AC97 interface (ready/to_ac97_data).
// PARAMETERS
//  NUM_CLIPS  8   number of clip table entries (>=2; SEL_W = $clog2(NUM_CLIPS))
//  ADDR_W     23  flash word address width
//  SAMPLE_W   8   output sample width; taken from frdata[15:16-SAMPLE_W]
//  DECIM      1   ready strobes per flash word (1 = 48 kHz, 8 = 6 kHz file rate)
// PORTS
//  clock         in   1       27 MHz system clock
//  reset         in   1       synchronous, active-high
//  cfg_we        in   1       write clip table entry cfg_idx this cycle
//  cfg_idx       in   SEL_W   table entry index
//  cfg_start     in   ADDR_W  clip start word address
//  cfg_len       in   ADDR_W  clip length in flash words
//  sel           in   SEL_W   clip to play, sampled on trigger
//  trigger       in   1       level; rising edge starts/restarts playback
//  stop          in   1       level; forces IDLE while high
//  loop_en       in   1       1 = restart clip at end instead of finishing
//  ready         in   1       AC97 sample strobe (level; rising edge used)
//  frdata        in   16      flash read data
//  busy          in   1       flash_manager busy (frdata not valid)
//  raddr         out  ADDR_W  flash read address
//  doread        out  1       read request to flash_manager
//  to_ac97_data  out  SAMPLE_W sample to headphone
//  playing       out  1       1 while in PLAY
//  done          out  1       one-cycle pulse at clip end / zero-length trigger
//  underruns     out  16      count of ready edges that saw busy=1 (saturating)
// BEHAVIOUR
//  - Reset: all table entries start=0,len=0; raddr=0, doread=0, to_ac97_data=0,
//    playing=0, done=0, underruns=0, state IDLE, edge registers cleared to 0.
//  - Edges: trig_re = trigger & ~trigger_q; rdy_re = ready & ~ready_q (regs).
//  - States: IDLE, PLAY. doread=1 only in PLAY.
//  - IDLE -> PLAY on trig_re (stop=0, len[sel]!=0): next cycle raddr=start[sel],
//    offset=0, decim_cnt=0, playing=1. len[sel]==0: stay IDLE, done=1 next cycle.
//  - PLAY, trig_re: retrigger; reload from sel exactly as from IDLE (no done).
//  - PLAY, rdy_re: if busy=0, to_ac97_data <= frdata[15:16-SAMPLE_W]; if busy=1
//    hold previous sample, underruns++ (saturate 16'hFFFF). Then decim_cnt++;
//    at decim_cnt==DECIM-1: decim_cnt=0, offset++, raddr=start+offset+1
//    (mod 2^ADDR_W, wraps silently).
//  - End: when offset reaches len (advance from len-1): loop_en=1 -> offset=0,
//    raddr=start, stay PLAY, done=1 one cycle; loop_en=0 -> IDLE, playing=0,
//    doread=0, to_ac97_data=0, done=1 one cycle.
//  - stop=1: IDLE next cycle, to_ac97_data=0, no done; overrides trig_re.
//  - Priority in one cycle: reset > stop > trig_re > end-of-clip > rdy_re advance.
//  - Start/len latched at trigger; cfg_we to the active entry during PLAY does
//    not affect current playback. cfg_we and trigger same cycle, same index:
//    playback uses the OLD entry.
//  - cfg_idx >= NUM_CLIPS: write ignored. sel >= NUM_CLIPS: treated as len=0.
// TESTING
//  1 Reset, cfg entry 2 = (1000,4), DECIM=1, trig sel=2, 6 ready edges, busy=0,
//    frdata=16'hAB00+addr -> raddr 1000..1003, samples AB.., done pulse after
//    4th, playing=0, to_ac97_data=0.
//  2 DECIM=8, entry (20001,2): 16 ready edges -> raddr 20001 for 8 edges, 20002
//    for 8, then IDLE with single done pulse.
//  3 loop_en=1, entry (500,3): 7 ready edges -> raddr 500,501,502,500,501,502,500;
//    done pulses twice, playing stays 1.
//  4 Retrigger mid-clip to sel=1 (3000,5) -> raddr=3000 next cycle, no done;
//    trigger with len=0 -> done=1, stays IDLE.
//  5 busy=1 on 3 ready edges -> underruns=3, sample held; stop=1 -> IDLE, out 0.
//  6 Start 2^23-2, len 4 -> raddr 7FFFFE,7FFFFF,0,1; reset mid-PLAY -> all 0.

Source files
------------

// File: rtl/audio_clip_player.sv
// Multi-clip flash audio player: a programmable (start, length) clip table feeding
// a one-shot/looping stream from flash_manager to the AC97 sample output.
module audio_clip_player #(
    parameter int NUM_CLIPS = 8,
    parameter int ADDR_W    = 23,
    parameter int SAMPLE_W  = 8,
    parameter int DECIM     = 1,
    localparam int SEL_W    = $clog2(NUM_CLIPS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_idx,
    input  logic [ADDR_W-1:0]   cfg_start,
    input  logic [ADDR_W-1:0]   cfg_len,
    input  logic [SEL_W-1:0]    sel,
    input  logic                trigger,
    input  logic                stop,
    input  logic                loop_en,
    input  logic                ready,
    input  logic [15:0]         frdata,
    input  logic                busy,
    output logic [ADDR_W-1:0]   raddr,
    output logic                doread,
    output logic [SAMPLE_W-1:0] to_ac97_data,
    output logic                playing,
    output logic                done,
    output logic [15:0]         underruns,
    output logic                state_dbg
);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                trigger_q, ready_q;
    logic [ADDR_W-1:0]   start_tab_q [NUM_CLIPS];
    logic [ADDR_W-1:0]   len_tab_q   [NUM_CLIPS];
    logic [ADDR_W-1:0]   cur_start_q, cur_start_d;
    logic [ADDR_W-1:0]   cur_len_q, cur_len_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [DW-1:0]       decim_q, decim_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                done_q, done_d;
    logic [15:0]         under_q, under_d;

    logic                trig_re, rdy_re, cfg_ok, sel_ok;
    logic [ADDR_W-1:0]   sel_start, sel_len, offset_inc;

    assign trig_re    = trigger & ~trigger_q;
    assign rdy_re     = ready & ~ready_q;
    assign cfg_ok     = ({{(32-SEL_W){1'b0}}, cfg_idx} < NUM_CLIPS);
    assign sel_ok     = ({{(32-SEL_W){1'b0}}, sel} < NUM_CLIPS);
    // The table is read before this cycle's cfg write lands, so a same-cycle
    // write/trigger on one entry plays the old contents.
    assign sel_start  = sel_ok ? start_tab_q[sel] : '0;
    assign sel_len    = sel_ok ? len_tab_q[sel] : '0;
    assign offset_inc = offset_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        cur_start_d = cur_start_q;
        cur_len_d   = cur_len_q;
        offset_d    = offset_q;
        decim_d     = decim_q;
        raddr_d     = raddr_q;
        sample_d    = sample_q;
        done_d      = 1'b0;
        under_d     = under_q;
        if (stop) begin
            state_d  = IDLE;
            sample_d = '0;
        end else if (trig_re) begin
            if (sel_len != '0) begin
                state_d     = PLAY;
                cur_start_d = sel_start;
                cur_len_d   = sel_len;
                raddr_d     = sel_start;
                offset_d    = '0;
                decim_d     = '0;
            end else begin
                state_d  = IDLE;
                sample_d = '0;
                done_d   = 1'b1;
            end
        end else if (state_q == PLAY && rdy_re) begin
            if (busy) begin
                if (under_q != 16'hFFFF) under_d = under_q + 16'd1;
            end else begin
                sample_d = frdata[15:16-SAMPLE_W];
            end
            if (decim_q == DW'(DECIM - 1)) begin
                decim_d = '0;
                if (offset_inc == cur_len_q) begin
                    done_d = 1'b1;
                    if (loop_en) begin
                        offset_d = '0;
                        raddr_d  = cur_start_q;
                    end else begin
                        state_d  = IDLE;
                        sample_d = '0;
                    end
                end else begin
                    offset_d = offset_inc;
                    raddr_d  = cur_start_q + offset_inc;
                end
            end else begin
                decim_d = decim_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            trigger_q   <= 1'b0;
            ready_q     <= 1'b0;
            cur_start_q <= '0;
            cur_len_q   <= '0;
            offset_q    <= '0;
            decim_q     <= '0;
            raddr_q     <= '0;
            sample_q    <= '0;
            done_q      <= 1'b0;
            under_q     <= '0;
            for (int i = 0; i < NUM_CLIPS; i++) begin
                start_tab_q[i] <= '0;
                len_tab_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            trigger_q   <= trigger;
            ready_q     <= ready;
            cur_start_q <= cur_start_d;
            cur_len_q   <= cur_len_d;
            offset_q    <= offset_d;
            decim_q     <= decim_d;
            raddr_q     <= raddr_d;
            sample_q    <= sample_d;
            done_q      <= done_d;
            under_q     <= under_d;
            if (cfg_we && cfg_ok) begin
                start_tab_q[cfg_idx] <= cfg_start;
                len_tab_q[cfg_idx]   <= cfg_len;
            end
        end
    end

    assign raddr        = raddr_q;
    assign doread       = (state_q == PLAY);
    assign playing      = (state_q == PLAY);
    assign to_ac97_data = sample_q;
    assign done         = done_q;
    assign underruns    = under_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_audio_clip_player.sv
// Bench for audio_clip_player: DECIM=1 and DECIM=8 instances share stimulus and are
// compared every cycle against a position-from-edge-count playback model.
module tb_audio_clip_player;
    localparam int AW = 23;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset = 1'b1, cfg_we = 1'b0, trigger = 1'b0, stop = 1'b0;
    logic          loop_en = 1'b0, ready = 1'b0, busy = 1'b0;
    logic [2:0]    cfg_idx = '0, sel = '0;
    logic [AW-1:0] cfg_start = '0, cfg_len = '0;
    logic [15:0]   frdata = '0;

    logic [1:0][AW-1:0] raddr_w;
    logic [1:0][7:0]    data_w;
    logic [1:0][15:0]   under_w;
    logic [1:0]         doread_w, playing_w, done_w, state_w;

    audio_clip_player #(.DECIM(1)) u_dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .sel(sel), .trigger(trigger),
        .stop(stop), .loop_en(loop_en), .ready(ready), .frdata(frdata), .busy(busy),
        .raddr(raddr_w[0]), .doread(doread_w[0]), .to_ac97_data(data_w[0]),
        .playing(playing_w[0]), .done(done_w[0]), .underruns(under_w[0]),
        .state_dbg(state_w[0]));

    audio_clip_player #(.DECIM(8)) u_dut8 (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .sel(sel), .trigger(trigger),
        .stop(stop), .loop_en(loop_en), .ready(ready), .frdata(frdata), .busy(busy),
        .raddr(raddr_w[1]), .doread(doread_w[1]), .to_ac97_data(data_w[1]),
        .playing(playing_w[1]), .done(done_w[1]), .underruns(under_w[1]),
        .state_dbg(state_w[1]));

    // Reference model: the play position is derived from the number of ready
    // edges seen since the last trigger, not from any counter structure.
    logic [AW-1:0] tab_start [8];
    logic [AW-1:0] tab_len   [8];
    bit            trig_prev, rdy_prev;
    bit            m_play [2];
    bit            m_done [2];
    logic [AW-1:0] m_start [2];
    logic [AW-1:0] m_len   [2];
    logic [AW-1:0] m_raddr [2];
    int            m_edges [2];
    int            m_under [2];
    logic [7:0]    m_sample [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h t=%0t", tag, inst, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit tre, rre;
        int dec, words;
        logic [AW-1:0] l;
        tre = trigger && !trig_prev;
        rre = ready && !rdy_prev;
        for (int m = 0; m < 2; m++) begin
            dec = (m == 0) ? 1 : 8;
            m_done[m] = 1'b0;
            if (reset) begin
                m_play[m] = 1'b0; m_raddr[m] = '0; m_sample[m] = '0; m_under[m] = 0;
                m_start[m] = '0; m_len[m] = '0; m_edges[m] = 0;
            end else if (stop) begin
                m_play[m] = 1'b0; m_sample[m] = '0;
            end else if (tre) begin
                l = tab_len[sel];
                if (l != '0) begin
                    m_play[m] = 1'b1; m_start[m] = tab_start[sel]; m_len[m] = l;
                    m_edges[m] = 0; m_raddr[m] = tab_start[sel];
                end else begin
                    m_play[m] = 1'b0; m_sample[m] = '0; m_done[m] = 1'b1;
                end
            end else if (m_play[m] && rre) begin
                if (busy) begin
                    if (m_under[m] < 65535) m_under[m]++;
                end else begin
                    m_sample[m] = frdata[15:8];
                end
                m_edges[m]++;
                words = m_edges[m] / dec;
                if (m_edges[m] % (int'(m_len[m]) * dec) == 0) begin
                    m_done[m] = 1'b1;
                    if (loop_en) m_raddr[m] = m_start[m];
                    else begin
                        m_play[m] = 1'b0; m_sample[m] = '0;
                    end
                end else begin
                    m_raddr[m] = m_start[m] + AW'(words % int'(m_len[m]));
                end
            end
        end
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                tab_start[i] = '0; tab_len[i] = '0;
            end
        end else if (cfg_we) begin
            tab_start[cfg_idx] = cfg_start;
            tab_len[cfg_idx]   = cfg_len;
        end
        trig_prev = reset ? 1'b0 : trigger;
        rdy_prev  = reset ? 1'b0 : ready;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("raddr", m, 32'(raddr_w[m]), 32'(m_raddr[m]));
            chk("doread", m, 32'(doread_w[m]), 32'(m_play[m]));
            chk("playing", m, 32'(playing_w[m]), 32'(m_play[m]));
            chk("sample", m, 32'(data_w[m]), 32'(m_sample[m]));
            chk("done", m, 32'(done_w[m]), 32'(m_done[m]));
            chk("underruns", m, 32'(under_w[m]), 32'(m_under[m]));
        end
        frdata = 16'($urandom);
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [AW-1:0] st, input logic [AW-1:0] ln);
        cfg_we = 1'b1; cfg_idx = idx; cfg_start = st; cfg_len = ln;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic trig(input logic [2:0] s);
        sel = s; trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
    endtask

    task automatic rdy(input int n);
        repeat (n) begin
            ready = 1'b1; step();
            ready = 1'b0; step();
        end
    endtask

    initial begin
        step(); step();
        reset = 1'b0;
        step();
        // One-shot DECIM=1 clip, then run on past its end.
        cfg(3'd2, 23'd1000, 23'd4);
        trig(3'd2);
        rdy(6);
        // Two-word clip, long enough for the DECIM=8 instance to finish too.
        cfg(3'd3, 23'd20001, 23'd2);
        trig(3'd3);
        rdy(16);
        // Looping clip.
        loop_en = 1'b1;
        cfg(3'd4, 23'd500, 23'd3);
        trig(3'd4);
        rdy(7);
        loop_en = 1'b0;
        stop = 1'b1; step(); stop = 1'b0; step();
        // Retrigger mid-clip, zero-length trigger, same-cycle write and trigger.
        cfg(3'd1, 23'd3000, 23'd5);
        trig(3'd2);
        rdy(2);
        trig(3'd1);
        rdy(1);
        trig(3'd5);
        cfg_we = 1'b1; cfg_idx = 3'd1; cfg_start = 23'd7777; cfg_len = 23'd2;
        sel = 3'd1; trigger = 1'b1;
        step();
        cfg_we = 1'b0; trigger = 1'b0;
        step();
        rdy(3);
        // Underruns hold the sample, then stop.
        trig(3'd1);
        rdy(1);
        busy = 1'b1;
        rdy(3);
        busy = 1'b0;
        stop = 1'b1; step(); stop = 1'b0; step();
        // Address wrap at the top of flash, then reset mid-play.
        cfg(3'd6, 23'h7FFFFE, 23'd4);
        trig(3'd6);
        rdy(3);
        reset = 1'b1; step(); reset = 1'b0; step();
        // Randomized traffic.
        repeat (1500) begin
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_idx   = 3'($urandom);
            cfg_start = AW'($urandom);
            cfg_len   = AW'($urandom_range(0, 5));
            sel       = 3'($urandom);
            if ($urandom_range(0, 15) == 0) trigger = ~trigger;
            if ($urandom_range(0, 2) != 0) ready = ~ready;
            busy      = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 80) == 0);
            reset     = ($urandom_range(0, 400) == 0);
            if ($urandom_range(0, 50) == 0) loop_en = ~loop_en;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
